// File: rtl/mips_load_extend_pipe.sv
// Load-data extractor for a MIPS-style memory stage: picks a byte, half,
// word or double out of a raw little-endian memory word, sign- or
// zero-extends it, flags misaligned/illegal accesses and carries the result
// through a valid/ready pipeline of PIPE_DEPTH register stages.
module mips_load_extend_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_DEPTH = 1,
  parameter int OFS_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFS_W-1:0]      in_offset,
  input  logic [1:0]            in_size,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_misaligned,
  output logic [7:0]            err_count
);

  logic [OFS_W+2:0]      shamt_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] keep_s;
  logic                  fill_s;
  logic                  mis_s;
  logic [DATA_WIDTH-1:0] res_s;

  // Byte offset scaled to a bit shift so the field lands at bit 0.
  assign shamt_s   = {in_offset, 3'b000};
  assign shifted_s = in_data >> shamt_s;

  // Field mask, sign-fill bit and alignment check per access size.
  // A double on a 32-bit datapath is always illegal.
  always_comb begin
    keep_s = '1;
    fill_s = 1'b0;
    mis_s  = 1'b0;
    case (in_size)
      2'd0: begin
        keep_s = DATA_WIDTH'(64'h0000_0000_0000_00FF);
        fill_s = in_signed & shifted_s[7];
        mis_s  = 1'b0;
      end
      2'd1: begin
        keep_s = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
        fill_s = in_signed & shifted_s[15];
        mis_s  = in_offset[0];
      end
      2'd2: begin
        keep_s = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
        fill_s = in_signed & shifted_s[31];
        mis_s  = (in_offset[1:0] != 2'b00);
      end
      2'd3: begin
        keep_s = '1;
        fill_s = 1'b0;
        mis_s  = (DATA_WIDTH == 32) || (in_offset != '0);
      end
      default: begin
        keep_s = '1;
        fill_s = 1'b0;
        mis_s  = 1'b1;
      end
    endcase
  end

  // Misaligned/illegal entries carry a zero result.
  assign res_s = mis_s ? '0
               : ((shifted_s & keep_s) | ({DATA_WIDTH{fill_s}} & ~keep_s));

  logic [PIPE_DEPTH-1:0] stage_valid_s;
  logic [PIPE_DEPTH-1:0] stage_mis_s;
  logic [DATA_WIDTH-1:0] stage_data_s [PIPE_DEPTH];
  logic                  last_rdy_s;

  // The last stage frees up when empty or when its result leaves; an
  // earlier stage frees up when empty or when the stage after it moves.
  assign last_rdy_s = ~stage_valid_s[PIPE_DEPTH-1] | out_ready;
  assign in_ready   = (PIPE_DEPTH == 1) ? last_rdy_s
                                        : (~stage_valid_s[0] | last_rdy_s);

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    logic                  up_valid_s;
    logic                  up_mis_s;
    logic [DATA_WIDTH-1:0] up_data_s;
    logic                  take_s;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    if (g == 0) begin : g_head
      assign up_valid_s = in_valid;
      assign up_mis_s   = mis_s;
      assign up_data_s  = res_s;
      assign take_s     = in_ready;
    end else begin : g_tail
      assign up_valid_s = stage_valid_s[g-1];
      assign up_mis_s   = stage_mis_s[g-1];
      assign up_data_s  = stage_data_s[g-1];
      assign take_s     = last_rdy_s;
    end

    // Stage next state: flush empties it, otherwise load from upstream when free.
    always_comb begin
      valid_d = valid_q;
      mis_d   = mis_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (take_s) begin
        valid_d = up_valid_s;
        if (up_valid_s) begin
          mis_d  = up_mis_s;
          data_d = up_data_s;
        end else begin
          mis_d  = mis_q;
          data_d = data_q;
        end
      end else begin
        valid_d = valid_q;
      end
    end

    // Stage registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        mis_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        mis_q   <= mis_d;
        data_q  <= data_d;
      end
    end

    assign stage_valid_s[g] = valid_q;
    assign stage_mis_s[g]   = mis_q;
    assign stage_data_s[g]  = data_q;
  end

  assign out_valid      = stage_valid_s[PIPE_DEPTH-1];
  assign out_misaligned = stage_mis_s[PIPE_DEPTH-1];
  assign out_data       = stage_data_s[PIPE_DEPTH-1];

  logic [7:0] err_q, err_d;

  // Count delivered misaligned results, holding at 255.
  always_comb begin
    err_d = err_q;
    if (out_valid && out_ready && out_misaligned && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Error counter register; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;

endmodule
